// File: rtl/tri_phase_pkg.sv
// Shared definitions for the three-phase DDS configuration sequencer:
// register map, CTRL/STATUS bit positions, FSM encoding and the ID constant.
// Optional feature macro: TRI_PHASE_AUTO_OFFSET_EN (derive PHB/PHC from PHA).
package tri_phase_pkg;

  localparam logic [2:0] A_FREQ_L = 3'd0;
  localparam logic [2:0] A_FREQ_H = 3'd1;
  localparam logic [2:0] A_PHA    = 3'd2;
  localparam logic [2:0] A_PHB    = 3'd3;
  localparam logic [2:0] A_PHC    = 3'd4;
  localparam logic [2:0] A_CTRL   = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_ID     = 3'd7;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_RUN     = 1;
  localparam int CTRL_IRQ_CLR = 2;
  localparam int CTRL_BYPASS  = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_ERR     = 3;

  localparam logic [15:0] ID_VALUE   = 16'h3A01;
  // 120 and 240 degree offsets of a 16-bit phase circle
  localparam logic [15:0] AUTO_OFS_B = 16'h5555;
  localparam logic [15:0] AUTO_OFS_C = 16'hAAAA;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_SYNC = 3'd2,
    S_LOAD      = 3'd3,
    S_DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/tri_phase_ctrl_sync_timer.sv
// Wait-for-sync timer: counts cycles spent in WAIT_SYNC and decides when the
// pending configuration may be applied (wrap, bypass, stopped DDS or expiry).
module tri_phase_sync_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic acc_wrap,
  input  logic bypass,
  input  logic run,
  output logic go,
  output logic timed_out
);
  import tri_phase_pkg::*;

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired;
  logic          sync_ok;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));
  assign sync_ok = acc_wrap | bypass | ~run;

  // Counter clears while arming and advances each waiting cycle, parking at expiry
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign go        = en & (sync_ok | expired);
  // Only flag a timeout when expiry alone forced the load
  assign timed_out = en & expired & ~sync_ok;

endmodule

// File: rtl/tri_phase_ctrl.sv
// Three-phase DDS configuration sequencer. Software writes shadow freq/phase
// registers; a commit snapshots them and applies all three channels in one
// cycle aligned to a channel-A accumulator wrap (or forced on bypass/stop/timeout).
// Optional feature macro: TRI_PHASE_AUTO_OFFSET_EN (PHB/PHC = PHA + 1/3, 2/3 turn).
module tri_phase_ctrl #(
  parameter int FW      = 32,
  parameter int PW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          wr_stb,
  input  logic          rd_stb,
  input  logic [2:0]    addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  input  logic          acc_wrap,
  output logic [FW-1:0] freq_word,
  output logic [PW-1:0] phase_a,
  output logic [PW-1:0] phase_b,
  output logic [PW-1:0] phase_c,
  output logic          dds_run,
  output logic          load,
  output logic          busy,
  output logic          irq
);
  import tri_phase_pkg::*;

`ifdef TRI_PHASE_AUTO_OFFSET_EN
  localparam logic [PW-1:0] RST_B = PW'(AUTO_OFS_B);
  localparam logic [PW-1:0] RST_C = PW'(AUTO_OFS_C);
`else
  localparam logic [PW-1:0] RST_B = '0;
  localparam logic [PW-1:0] RST_C = '0;
`endif

  state_e state_q, state_d;

  logic [15:0]   freq_l_q, freq_l_d, freq_h_q, freq_h_d;
  logic [PW-1:0] pha_q, pha_d;
  logic [PW-1:0] phb_sh, phc_sh;
  logic          run_q, run_d, bypass_q, bypass_d;
  logic          done_q, done_d, to_q, to_d, err_q, err_d, irq_q, irq_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [FW-1:0] pend_f_q, pend_f_d, act_f_q, act_f_d;
  logic [PW-1:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d, pend_c_q, pend_c_d;
  logic [PW-1:0] act_a_q, act_a_d, act_b_q, act_b_d, act_c_q, act_c_d;

  logic wr, rd, commit_req, start, snap, apply, in_done, is_busy;
  logic go, timed_out;

  assign wr         = cs & wr_stb;
  assign rd         = cs & rd_stb;
  assign commit_req = wr & (addr == A_CTRL) & wdata[CTRL_COMMIT];
  assign is_busy    = (state_q != S_IDLE);
  assign start      = commit_req & ~is_busy;

`ifdef TRI_PHASE_AUTO_OFFSET_EN
  assign phb_sh = pha_q + PW'(AUTO_OFS_B);
  assign phc_sh = pha_q + PW'(AUTO_OFS_C);
`else
  logic [PW-1:0] phb_q, phb_d, phc_q, phc_d;
  assign phb_sh = phb_q;
  assign phc_sh = phc_q;

  // PHB/PHC shadows are plain software registers in this build
  always_comb begin
    phb_d = phb_q;
    phc_d = phc_q;
    if (wr && !is_busy && addr == A_PHB) phb_d = PW'(wdata);
    if (wr && !is_busy && addr == A_PHC) phc_d = PW'(wdata);
  end

  // PHB/PHC shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phb_q <= '0;
      phc_q <= '0;
    end else begin
      phb_q <= phb_d;
      phc_q <= phc_d;
    end
  end
`endif

  tri_phase_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_q == S_ARM),
    .en        (state_q == S_WAIT_SYNC),
    .acc_wrap  (acc_wrap),
    .bypass    (bypass_q),
    .run       (run_q),
    .go        (go),
    .timed_out (timed_out)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; wraps seen during ARM are ignored because the timer is idle there
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_ARM;
      S_ARM:       state_d = S_WAIT_SYNC;
      S_WAIT_SYNC: if (go) state_d = S_LOAD;
      S_LOAD:      state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM outputs: snapshot on ARM entry, apply on LOAD entry
  always_comb begin
    snap    = (state_q == S_IDLE) & start;
    apply   = (state_q == S_WAIT_SYNC) & go;
    load    = (state_q == S_LOAD);
    in_done = (state_q == S_DONE);
    busy    = is_busy;
  end

  // Shadow, control and sticky status updates; flag sets win over clears
  always_comb begin
    freq_l_d = freq_l_q;
    freq_h_d = freq_h_q;
    pha_d    = pha_q;
    run_d    = run_q;
    bypass_d = bypass_q;
    done_d   = done_q;
    to_d     = to_q;
    err_d    = err_q;
    irq_d    = irq_q;
    if (wr && !is_busy) begin
      if (addr == A_FREQ_L) freq_l_d = wdata;
      if (addr == A_FREQ_H) freq_h_d = wdata;
      if (addr == A_PHA)    pha_d    = PW'(wdata);
    end
    if (wr && addr == A_CTRL) begin
      run_d    = wdata[CTRL_RUN];
      bypass_d = wdata[CTRL_BYPASS];
      if (wdata[CTRL_IRQ_CLR]) irq_d = 1'b0;
    end
    if (wr && addr == A_STATUS) begin
      if (wdata[ST_DONE])    done_d = 1'b0;
      if (wdata[ST_TIMEOUT]) to_d   = 1'b0;
      if (wdata[ST_ERR])     err_d  = 1'b0;
    end
    if (is_busy && ((wr && addr <= A_PHC) || commit_req)) err_d = 1'b1;
    if (apply && timed_out) to_d = 1'b1;
    if (in_done) begin
      done_d = 1'b1;
      irq_d  = 1'b1;
    end
  end

  // Pending snapshot and active outputs
  always_comb begin
    pend_f_d = pend_f_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    pend_c_d = pend_c_q;
    act_f_d  = act_f_q;
    act_a_d  = act_a_q;
    act_b_d  = act_b_q;
    act_c_d  = act_c_q;
    if (snap) begin
      pend_f_d = FW'({freq_h_q, freq_l_q});
      pend_a_d = pha_q;
      pend_b_d = phb_sh;
      pend_c_d = phc_sh;
    end
    if (apply) begin
      act_f_d = pend_f_q;
      act_a_d = pend_a_q;
      act_b_d = pend_b_q;
      act_c_d = pend_c_q;
    end
  end

  // Registered read port, held between reads
  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (addr)
        A_FREQ_L: rdata_d = freq_l_q;
        A_FREQ_H: rdata_d = freq_h_q;
        A_PHA:    rdata_d = 16'(pha_q);
        A_PHB:    rdata_d = 16'(phb_sh);
        A_PHC:    rdata_d = 16'(phc_sh);
        A_CTRL:   rdata_d = {12'd0, bypass_q, 1'b0, run_q, 1'b0};
        A_STATUS: rdata_d = {12'd0, err_q, to_q, done_q, is_busy};
        A_ID:     rdata_d = ID_VALUE;
        default:  rdata_d = '0;
      endcase
    end
  end

  // Register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_l_q <= '0;  freq_h_q <= '0;  pha_q    <= '0;
      run_q    <= 1'b0; bypass_q <= 1'b0;
      done_q   <= 1'b0; to_q     <= 1'b0; err_q <= 1'b0; irq_q <= 1'b0;
      rdata_q  <= '0;
      pend_f_q <= '0;  pend_a_q <= '0;  pend_b_q <= RST_B; pend_c_q <= RST_C;
      act_f_q  <= '0;  act_a_q  <= '0;  act_b_q  <= RST_B; act_c_q  <= RST_C;
    end else begin
      freq_l_q <= freq_l_d; freq_h_q <= freq_h_d; pha_q <= pha_d;
      run_q    <= run_d;    bypass_q <= bypass_d;
      done_q   <= done_d;   to_q     <= to_d; err_q <= err_d; irq_q <= irq_d;
      rdata_q  <= rdata_d;
      pend_f_q <= pend_f_d; pend_a_q <= pend_a_d; pend_b_q <= pend_b_d; pend_c_q <= pend_c_d;
      act_f_q  <= act_f_d;  act_a_q  <= act_a_d;  act_b_q  <= act_b_d;  act_c_q  <= act_c_d;
    end
  end

  assign rdata     = rdata_q;
  assign freq_word = act_f_q;
  assign phase_a   = act_a_q;
  assign phase_b   = act_b_q;
  assign phase_c   = act_c_q;
  assign dds_run   = run_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_tri_phase_ctrl.sv
// Directed bench for tri_phase_ctrl: expected values are queued when stimulus
// is driven and popped when the DUT produces a read or a load pulse.
module tb_tri_phase_ctrl;
  localparam int TO = 1024;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cs = 1'b0, wr_stb = 1'b0, rd_stb = 1'b0, acc_wrap = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic [31:0] freq_word;
  logic [15:0] phase_a, phase_b, phase_c;
  logic        dds_run, load, busy, irq;

  int n_assert = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

`ifdef TRI_PHASE_AUTO_OFFSET_EN
  localparam logic [15:0] RB = 16'h5555, RC = 16'hAAAA;
  localparam logic [15:0] B1000 = 16'h6555, C1000 = 16'hBAAA;
`else
  localparam logic [15:0] RB = 16'h0000, RC = 16'h0000;
  localparam logic [15:0] B1000 = 16'h5555, C1000 = 16'hAAAA;
`endif

  tri_phase_ctrl #(.FW(32), .PW(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_stb(wr_stb), .rd_stb(rd_stb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .acc_wrap(acc_wrap),
    .freq_word(freq_word), .phase_a(phase_a), .phase_b(phase_b), .phase_c(phase_c),
    .dds_run(dds_run), .load(load), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk); cs = 1'b1; wr_stb = 1'b1; addr = a; wdata = d;
    @(negedge clk); cs = 1'b0; wr_stb = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk); cs = 1'b1; rd_stb = 1'b1; addr = a;
    push(tag, {16'd0, exp});
    @(negedge clk); cs = 1'b0; rd_stb = 1'b0;
    @(posedge clk); #1;
    pop_check({16'd0, rdata});
  endtask

  // Queue the four active values expected at the next load pulse
  task automatic push_load(input string tag, input logic [31:0] f,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    push({tag, "_freq"}, f);
    push({tag, "_pha"}, {16'd0, a});
    push({tag, "_phb"}, {16'd0, b});
    push({tag, "_phc"}, {16'd0, c});
  endtask

  // Count negedges until load is seen; pops the queued active values there
  task automatic wait_load(input string tag, input int max, output int k);
    bit found = 1'b0;
    k = 0;
    while (k < max && !found) begin
      @(negedge clk); acc_wrap = 1'b0; k++;
      if (load) found = 1'b1;
    end
    check({tag, "_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      pop_check(freq_word);
      pop_check({16'd0, phase_a});
      pop_check({16'd0, phase_b});
      pop_check({16'd0, phase_c});
    end else begin
      repeat (4) begin void'(exp_q.pop_front()); void'(tag_q.pop_front()); end
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (k < max && busy) begin @(negedge clk); k++; end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    int nload;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_freq", freq_word, 32'd0);
    check("rst_pha", {16'd0, phase_a}, 32'd0);
    check("rst_phb", {16'd0, phase_b}, {16'd0, RB});
    check("rst_phc", {16'd0, phase_c}, {16'd0, RC});
    check("rst_ctl", {28'd0, dds_run, load, busy, irq}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    rst_n = 1'b1;
    rd(3'd7, 16'h3A01, "id");

    // wrap-aligned commit
    wr(3'd0, 16'h1234); wr(3'd1, 16'h0056);
    wr(3'd2, 16'h0000); wr(3'd3, 16'h5555); wr(3'd4, 16'hAAAA);
    rd(3'd0, 16'h1234, "freq_l_rb");
    push_load("wrap", 32'h0056_1234, 16'h0000, 16'h5555, 16'hAAAA);
    wr(3'd5, 16'h0003);
    check("run_set", {31'd0, dds_run}, 32'd1);
    repeat (10) @(negedge clk);
    check("wait_busy", {30'd0, busy, load}, 32'd2);
    acc_wrap = 1'b1;
    wait_load("wrap", 5, k);
    check("wrap_lat", k, 32'd1);
    @(negedge clk);
    check("wrap_pulse1", {31'd0, load}, 32'd0);
    wait_idle("wrap", 8);
    check("wrap_irq", {31'd0, irq}, 32'd1);
    rd(3'd6, 16'h0002, "wrap_status");

    // irq clear (also drops run), clear done
    wr(3'd5, 16'h0004);
    check("irq_clr", {30'd0, irq, dds_run}, 32'd0);
    wr(3'd6, 16'h0002);
    rd(3'd6, 16'h0000, "done_clr");

    // timeout: run=1, no wrap
    wr(3'd0, 16'hBEEF);
    push_load("to", 32'h0056_BEEF, 16'h0000, 16'h5555, 16'hAAAA);
    wr(3'd5, 16'h0003);
    wait_load("to", TO + 10, k);
    check("to_lat", k, TO + 1);
    wait_idle("to", 8);
    rd(3'd6, 16'h0006, "to_status");
    wr(3'd6, 16'h0006);

    // write during WAIT_SYNC dropped, err flagged
    push_load("err", 32'h0056_BEEF, 16'h0000, 16'h5555, 16'hAAAA);
    wr(3'd5, 16'h0003);
    repeat (2) @(negedge clk);
    wr(3'd2, 16'h7777);
    acc_wrap = 1'b1;
    wait_load("err", 5, k);
    wait_idle("err", 8);
    rd(3'd2, 16'h0000, "err_pha_rb");
    rd(3'd6, 16'h000A, "err_status");
    wr(3'd6, 16'h0008);
    rd(3'd6, 16'h0002, "err_clr");

    // bypass commit, run off
    wr(3'd2, 16'h1000);
    push_load("byp", 32'h0056_BEEF, 16'h1000, B1000, C1000);
    wr(3'd5, 16'h0009);
    wait_load("byp", 8, k);
    check("byp_lat", k, 32'd2);
    check("byp_busy_load", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("byp_k3", {30'd0, load, busy}, 32'd1);
    @(negedge clk);
    check("byp_k4_busy", {31'd0, busy}, 32'd0);
    check("byp_run", {31'd0, dds_run}, 32'd0);
    rd(3'd3, B1000, "phb_rb");

    // clearing run mid-wait loads next cycle
    push_load("stop", 32'h0056_BEEF, 16'h1000, B1000, C1000);
    wr(3'd5, 16'h0003);
    repeat (3) @(negedge clk);
    wr(3'd5, 16'h0000);
    wait_load("stop", 4, k);
    check("stop_lat", k, 32'd1);
    wait_idle("stop", 8);

    // reset during WAIT_SYNC aborts without load
    wr(3'd5, 16'h0003);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_freq", freq_word, 32'd0);
    check("abort_pha", {16'd0, phase_a}, 32'd0);
    check("abort_ctl", {28'd0, dds_run, load, busy, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nload = 0;
    repeat (20) begin @(negedge clk); if (load) nload++; end
    check("abort_noload", nload, 32'd0);
    rd(3'd7, 16'h3A01, "id2");

    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
